// File: rtl/resample_interp.sv
// -----------------------------------------------------------------------------
// resample_interp
//
// Streaming rational-rate downsampler. A phase accumulator decides which
// input samples produce an output; each emitted sample is either linearly
// interpolated between the previous and current input (RESAMPLE_INTERP_EN
// defined) or a zero-order hold of the current input (RESAMPLE_INTERP_EN
// undefined, the default build, which contains no multipliers).
//
// Configuration macro:
//   RESAMPLE_INTERP_EN  defined   -> linear interpolation with fraction mu
//                       undefined -> zero-order hold (output = current input)
//
// Pipeline (all stages advance together on en):
//   stage 1: phase decision, fraction mu, capture current/previous sample
//   stage 2: per-lane (x_cur - x_prev) * mu
//   stage 3: per-lane add, output register
//
// Ports:
//   clk_in                  sole clock, rising edge
//   rst_in                  synchronous active-high reset
//   signal_axis_tvalid      input stream valid
//   signal_axis_tdata       input lanes, lane 0 in the LSBs
//   signal_axis_tready      input ready (= pipeline enable)
//   downsample_axis_tready  output stream ready
//   downsample_axis_tvalid  output stream valid
//   downsample_axis_tdata   output lanes, lane 0 in the LSBs
// -----------------------------------------------------------------------------
module resample_interp #(
  parameter int SAMPLE_RATE_IN  = 122_880,
  parameter int SAMPLE_RATE_OUT = 20_000,
  parameter int NUM_CHANNELS    = 2,
  parameter int CHANNEL_WIDTH   = 16,
  parameter int FRAC_BITS       = 12
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   signal_axis_tvalid,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]  signal_axis_tdata,
  output logic                                   signal_axis_tready,
  input  logic                                   downsample_axis_tready,
  output logic                                   downsample_axis_tvalid,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]  downsample_axis_tdata
);

  localparam int C_W    = $clog2(SAMPLE_RATE_IN) + 1;
  localparam int DATA_W = NUM_CHANNELS * CHANNEL_WIDTH;

  if (SAMPLE_RATE_OUT <= 0 || SAMPLE_RATE_OUT > SAMPLE_RATE_IN || FRAC_BITS < 1) begin : g_bad_config
    $error("resample_interp: requires 0 < SAMPLE_RATE_OUT <= SAMPLE_RATE_IN and FRAC_BITS >= 1");
  end

  // ---------------------------------------------------------------------------
  // Handshake and phase accumulator
  // ---------------------------------------------------------------------------
  logic           en;
  logic           accept;
  logic           emit;
  logic [C_W-1:0] c_sum;
  logic [C_W-1:0] c_q, c_d;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic out_valid_q, out_valid_d;

  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic signed [CHANNEL_WIDTH-1:0] s1_cur_q [NUM_CHANNELS];
  logic signed [CHANNEL_WIDTH-1:0] s1_cur_d [NUM_CHANNELS];

  // The whole pipeline moves as one: it advances whenever the output
  // register is empty or being drained this cycle.
  assign en                     = ~out_valid_q | downsample_axis_tready;
  assign signal_axis_tready     = en;
  assign downsample_axis_tvalid = out_valid_q;
  assign downsample_axis_tdata  = out_data_q;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    accept = signal_axis_tvalid & en;
    c_sum  = c_q + C_W'(SAMPLE_RATE_OUT);
    emit   = (c_sum >= C_W'(SAMPLE_RATE_IN));
    c_d    = c_q;
    if (accept) begin
      c_d = emit ? (c_sum - C_W'(SAMPLE_RATE_IN)) : c_sum;
    end
  end

  // Valid bits: a non-emitting or missing input becomes a bubble.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    out_valid_d = out_valid_q;
    if (en) begin
      s1_valid_d  = accept & emit;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      s1_cur_d[i] = s1_cur_q[i];
      if (en) begin
        s1_cur_d[i] = $signed(signal_axis_tdata[i*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
      end
    end
  end

`ifdef RESAMPLE_INTERP_EN
  // ---------------------------------------------------------------------------
  // Linear interpolation datapath
  // ---------------------------------------------------------------------------
  // mu = (IN - c_before) * floor(2^(FRAC_BITS+16) / OUT) >> 16, clamped to 1.0
  localparam longint unsigned MU_SCALE = (64'd1 << (FRAC_BITS + 16)) / 64'(SAMPLE_RATE_OUT);
  localparam int MS_W = FRAC_BITS + 17;
  localparam int MP_W = C_W + MS_W;
  localparam int MU_W = FRAC_BITS + 1;
  // Difference is CHANNEL_WIDTH+1 signed, mu is MU_W unsigned (+1 sign bit).
  localparam int PR_W = CHANNEL_WIDTH + FRAC_BITS + 3;
  localparam logic [MU_W-1:0] MU_ONE = {1'b1, {FRAC_BITS{1'b0}}};

  logic [C_W-1:0]  dist;
  logic [MP_W-1:0] mu_full;
  logic [MU_W-1:0] s1_mu_q, s1_mu_d;

  logic prev_valid_q, prev_valid_d;

  logic signed [CHANNEL_WIDTH-1:0] x_prev_q  [NUM_CHANNELS];
  logic signed [CHANNEL_WIDTH-1:0] x_prev_d  [NUM_CHANNELS];
  logic signed [CHANNEL_WIDTH-1:0] s1_prev_q [NUM_CHANNELS];
  logic signed [CHANNEL_WIDTH-1:0] s1_prev_d [NUM_CHANNELS];
  logic signed [CHANNEL_WIDTH-1:0] s2_prev_q [NUM_CHANNELS];
  logic signed [CHANNEL_WIDTH-1:0] s2_prev_d [NUM_CHANNELS];
  logic signed [PR_W-1:0]          s2_prod_q [NUM_CHANNELS];
  logic signed [PR_W-1:0]          s2_prod_d [NUM_CHANNELS];

  // Stage 1: fraction and previous-sample tracking.
  always_comb begin
    dist         = C_W'(SAMPLE_RATE_IN) - c_q;
    mu_full      = (MP_W'(dist) * MP_W'(MU_SCALE)) >> 16;
    s1_mu_d      = s1_mu_q;
    prev_valid_d = prev_valid_q | accept;
    if (en) begin
      // Without a previous sample the output must equal the current sample.
      if (!prev_valid_q || (mu_full > MP_W'(MU_ONE))) begin
        s1_mu_d = MU_ONE;
      end else begin
        s1_mu_d = mu_full[MU_W-1:0];
      end
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      x_prev_d[i]  = x_prev_q[i];
      s1_prev_d[i] = s1_prev_q[i];
      if (en) begin
        s1_prev_d[i] = x_prev_q[i];
      end
      // x_prev follows every accepted input, emitting or not.
      if (accept) begin
        x_prev_d[i] = $signed(signal_axis_tdata[i*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
      end
    end
  end

  // Stage 2: scaled difference.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      s2_prev_d[i] = s2_prev_q[i];
      s2_prod_d[i] = s2_prod_q[i];
      if (en) begin
        s2_prev_d[i] = s1_prev_q[i];
        s2_prod_d[i] = (PR_W'(s1_cur_q[i]) - PR_W'(s1_prev_q[i]))
                     * PR_W'($signed({1'b0, s1_mu_q}));
      end
    end
  end

  // Stage 3: x_prev + floor(diff*mu / 2^FRAC_BITS); result always fits a lane.
  always_comb begin
    out_data_d = out_data_q;
    if (en && s2_valid_q) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        out_data_d[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
          CHANNEL_WIDTH'(PR_W'(s2_prev_q[i]) + (s2_prod_q[i] >>> FRAC_BITS));
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prev_valid_q <= 1'b0;
      x_prev_q     <= '{default: '0};
    end else begin
      prev_valid_q <= prev_valid_d;
      x_prev_q     <= x_prev_d;
    end
  end

  always_ff @(posedge clk_in) begin
    s1_mu_q   <= s1_mu_d;
    s1_prev_q <= s1_prev_d;
    s2_prev_q <= s2_prev_d;
    s2_prod_q <= s2_prod_d;
  end

`else
  // ---------------------------------------------------------------------------
  // Zero-order hold datapath: same stage count, no arithmetic.
  // ---------------------------------------------------------------------------
  logic signed [CHANNEL_WIDTH-1:0] s2_cur_q [NUM_CHANNELS];
  logic signed [CHANNEL_WIDTH-1:0] s2_cur_d [NUM_CHANNELS];

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      s2_cur_d[i] = s2_cur_q[i];
      if (en) begin
        s2_cur_d[i] = s1_cur_q[i];
      end
    end
  end

  always_comb begin
    out_data_d = out_data_q;
    if (en && s2_valid_q) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        out_data_d[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] = s2_cur_q[i];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    s2_cur_q <= s2_cur_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Control state and output register
  // ---------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      c_q         <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      c_q         <= c_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: intermediate stage data is not reset; it is only ever consumed
  // under its stage valid bit, which is reset.
  always_ff @(posedge clk_in) begin
    s1_cur_q <= s1_cur_d;
  end

endmodule

// File: tb/tb_resample_interp.sv
// -----------------------------------------------------------------------------
// tb_resample_interp
//
// Two instances: dut_a (IN=5, OUT=2) runs a directed cycle-exact schedule
// with a free-running sink, checking latency, ramp values and mid-stream
// reset; dut_b (default rates) runs long randomized streams with
// backpressure against a scoreboard fed by a closed-form reference model.
// -----------------------------------------------------------------------------
module tb_resample_interp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_ivalid, a_iready, a_oready, a_ovalid;
  logic [31:0] a_idata, a_odata;
  logic        b_rst, b_ivalid, b_iready, b_oready, b_ovalid;
  logic [31:0] b_idata, b_odata;

  resample_interp #(
    .SAMPLE_RATE_IN (5),
    .SAMPLE_RATE_OUT(2),
    .NUM_CHANNELS   (2),
    .CHANNEL_WIDTH  (16),
    .FRAC_BITS      (12)
  ) dut_a (
    .clk_in                 (clk),
    .rst_in                 (a_rst),
    .signal_axis_tvalid     (a_ivalid),
    .signal_axis_tdata      (a_idata),
    .signal_axis_tready     (a_iready),
    .downsample_axis_tready (a_oready),
    .downsample_axis_tvalid (a_ovalid),
    .downsample_axis_tdata  (a_odata)
  );

  resample_interp dut_b (
    .clk_in                 (clk),
    .rst_in                 (b_rst),
    .signal_axis_tvalid     (b_ivalid),
    .signal_axis_tdata      (b_idata),
    .signal_axis_tready     (b_iready),
    .downsample_axis_tready (b_oready),
    .downsample_axis_tvalid (b_ovalid),
    .downsample_axis_tdata  (b_odata)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. After n accepted inputs the accumulator holds
  // (n*OUT) mod IN, so input n emits exactly when floor((n+1)*OUT/IN)
  // exceeds floor(n*OUT/IN).
  // ---------------------------------------------------------------------------
  function automatic bit m_emit(longint n, longint rin, longint rout);
    return ((n + 1) * rout) / rin > (n * rout) / rin;
  endfunction

  function automatic logic [31:0] m_out(logic [31:0] cur, logic [31:0] prev, bit first,
                                        longint n, longint rin, longint rout);
    logic [31:0] r;
    longint cb, mu, c, p, yi, y;
    r  = '0;
    cb = (n * rout) % rin;
    if (first) mu = 4096;
    else begin
      mu = ((rin - cb) * ((longint'(1) << 28) / rout)) >>> 16;
      if (mu > 4096) mu = 4096;
    end
    for (int i = 0; i < 2; i++) begin
      c  = longint'($signed(cur[i*16 +: 16]));
      p  = longint'($signed(prev[i*16 +: 16]));
      yi = p + (((c - p) * mu) >>> 12);
`ifdef RESAMPLE_INTERP_EN
      y = yi;
`else
      y = c;
`endif
      r[i*16 +: 16] = y[15:0];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // dut_a schedule and expectations (indexed by observation iteration)
  // ---------------------------------------------------------------------------
  localparam int NA = 44;
  bit          sa_rst [NA];
  bit          sa_v   [NA];
  logic [31:0] sa_d   [NA];
  bit          ea_v   [NA+3];
  logic [31:0] ea_d   [NA+3];

  // ---------------------------------------------------------------------------
  // dut_b scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] bq[$];
  longint      bn      = 0;
  logic [31:0] bprev   = '0;
  int          b_emits = 0;
  int          n_out   = 0;

  task automatic b_cycle(input bit v, input logic [31:0] d, input bit ordy);
    @(negedge clk);
    if (b_ovalid === 1'b1) begin
      if (bq.size() == 0) check("b_tvalid_spurious", b_ovalid, 1'b0);
      else                check("b_tdata", b_odata, bq[0]);
    end
    b_ivalid = v;
    b_idata  = d;
    b_oready = ordy;
    #1;
    check("b_tready", b_iready, (!b_ovalid) || ordy);
    if (b_ovalid && ordy && bq.size() > 0) begin
      void'(bq.pop_front());
      n_out++;
    end
    if (v && b_iready) begin
      if (m_emit(bn, 122880, 20000)) begin
        bq.push_back(m_out(d, bprev, bn == 0, bn, 122880, 20000));
        b_emits++;
      end
      bprev = d;
      bn++;
    end
  endtask

  initial begin
    longint      n;
    logic [31:0] prev;
    logic [31:0] d;
    logic [15:0] lane0;
    bit          found;

    a_rst = 1'b1; a_ivalid = 1'b0; a_idata = '0; a_oready = 1'b1;
    b_rst = 1'b1; b_ivalid = 1'b0; b_idata = '0; b_oready = 1'b1;

    // Build dut_a schedule: ramp, idle, ramp with reset, random, idle.
    for (int j = 0; j < NA; j++) begin
      sa_rst[j] = 1'b0;
      sa_v[j]   = 1'b0;
      sa_d[j]   = '0;
      if (j <= 7) begin
        sa_v[j] = 1'b1;
        lane0   = 16'(100 * j);
        sa_d[j] = {16'($urandom), lane0};
      end else if (j >= 12 && j <= 17) begin
        sa_v[j] = 1'b1;
        lane0   = 16'(100 * (j - 12));
        sa_d[j] = {16'($urandom), lane0};
        sa_rst[j] = (j == 17);
      end else if (j >= 18 && j < NA - 4) begin
        sa_v[j] = ($urandom_range(3) != 0);
        sa_d[j] = $urandom;
      end
    end
    for (int j = 0; j < NA + 3; j++) begin
      ea_v[j] = 1'b0;
      ea_d[j] = '0;
    end
    n = 0;
    prev = '0;
    for (int j = 0; j < NA; j++) begin
      if (sa_rst[j]) begin
        n = 0;
        prev = '0;
        for (int k = 1; k <= 3; k++) ea_v[j+k] = 1'b0;
      end else if (sa_v[j]) begin
        if (m_emit(n, 5, 2)) begin
          ea_v[j+3] = 1'b1;
          ea_d[j+3] = m_out(sa_d[j], prev, n == 0, n, 5, 2);
        end
        prev = sa_d[j];
        n++;
      end
    end

    repeat (2) @(negedge clk);
    b_rst = 1'b0;

    // dut_a: one observation then one drive per cycle.
    for (int j = 0; j < NA; j++) begin
      @(negedge clk);
      check("a_tvalid", a_ovalid, ea_v[j]);
      if (ea_v[j]) check("a_tdata", a_odata, ea_d[j]);
      if (j == 0 || j == 18) check("a_tdata_after_reset", a_odata, 32'd0);
      if (j == 18) check("a_tready_after_reset", a_iready, 1'b1);
`ifdef RESAMPLE_INTERP_EN
      if (j == 5) check("a_ramp_first_emit", a_odata[15:0], 16'd150);
`else
      if (j == 5) check("a_ramp_first_emit", a_odata[15:0], 16'd200);
`endif
      if (j == 7) check("a_ramp_second_emit", a_odata[15:0], 16'd400);
      a_rst    = sa_rst[j];
      a_ivalid = sa_v[j];
      a_idata  = sa_d[j];
    end

    // dut_b: reset state.
    @(negedge clk);
    check("b_tvalid_reset", b_ovalid, 1'b0);
    check("b_tdata_reset", b_odata, 32'd0);
    check("b_tready_reset", b_iready, 1'b1);

    // Continuous input at full rate; first emit lands on input 6.
    for (int k = 0; k < 12288; k++) begin
      d = (k < 8) ? {16'(-1000 * k), 16'(4096 * k)} : $urandom;
      b_cycle(1'b1, d, 1'b1);
    end
    repeat (5) b_cycle(1'b0, '0, 1'b1);
    check("b_ratio_count", n_out, 2000);
    check("b_ratio_model", n_out, b_emits);

    // Stall the sink for 10 cycles while an output is pending.
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (b_ovalid === 1'b1) found = 1'b1;
      else b_cycle(1'b1, $urandom, 1'b1);
    end
    check("b_stall_reached", b_ovalid, 1'b1);
    repeat (10) b_cycle(1'b1, $urandom, 1'b0);

    // Random valid and backpressure.
    for (int k = 0; k < 3000; k++)
      b_cycle($urandom_range(3) != 0, $urandom, $urandom_range(2) != 0);

    // Full-scale alternating lanes.
    for (int k = 0; k < 600; k++) begin
      d = k[0] ? 32'h7fff_8000 : 32'h8000_7fff;
      b_cycle(1'b1, d, $urandom_range(3) != 0);
    end

    repeat (20) b_cycle(1'b0, '0, 1'b1);
    check("b_all_delivered", bq.size(), 0);
    check("b_count", n_out, b_emits);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
